cpu_run_ctrl: RTL

Run/step controller for the single-cycle CPU on the board. It generates a one-cycle clock-enable pulse, cpu_ce, that advances the CPU datapath by exactly one instruction. It supports four modes: free-run at a divided rate, halt, debounced single-step from a push-button, and a PC breakpoint. It runs entirely on the board clock, and the CPU registers are gated by cpu_ce rather than by a derived clock.

---
 rtl/cpu_run_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: produces a one-cycle cpu_ce per instruction in free-run,
// single-step or breakpoint modes. Everything runs on out_clk.
//
// state | meaning
// HALT  | idle, waiting for run switch or step request
// RUN   | free-run, one cpu_ce per RUN_DIV cycles
// STEP  | single-instruction pulse, lasts one cycle
// BREAK | stopped on a breakpoint match, bp_hit high
module cpu_run_ctrl #(
  parameter int unsigned RUN_DIV    = 50000000,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned PC_W       = 32
) (
  input  logic            out_clk,
  input  logic            reset,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_ce,
  output logic [1:0]      state,
  output logic            bp_hit,
  output logic [31:0]     instr_count
);

  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t           cur_state;
  logic             run_meta, run_s;
  logic             btn_meta, btn_s;
  logic             btn_db, btn_db_q;
  logic             step_req;
  logic [DEB_W-1:0] deb_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             bp_match;

  assign state    = cur_state;
  assign tick     = (div_cnt == DIV_LAST);
  assign bp_match = bp_en && (pc == bp_addr);

  // Synchronizers, button debounce and rising-edge step request
  always_ff @(posedge out_clk) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
      btn_meta <= step_btn;
      btn_s    <= btn_meta;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      btn_db_q <= btn_db;
      step_req <= btn_db & ~btn_db_q;
    end
  end

  // Control FSM; cpu_ce and bp_hit are registered alongside the state
  always_ff @(posedge out_clk) begin
    if (reset) begin
      cur_state   <= S_HALT;
      cpu_ce      <= 1'b0;
      bp_hit      <= 1'b0;
      div_cnt     <= '0;
      instr_count <= '0;
    end else begin
      cpu_ce  <= 1'b0;
      bp_hit  <= 1'b0;
      div_cnt <= '0;
      if (cpu_ce) instr_count <= instr_count + 32'd1;
      case (cur_state)
        S_HALT: begin
          if (run_s) begin
            cur_state <= S_RUN;
          end else if (step_req) begin
            cur_state <= S_STEP;
            cpu_ce    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run_s) begin
            cur_state <= S_HALT;
          end else if (tick) begin
            // The instruction at bp_addr is held back, not executed
            if (bp_match) begin
              cur_state <= S_BREAK;
              bp_hit    <= 1'b1;
            end else begin
              cpu_ce <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_STEP: begin
          cur_state <= run_s ? S_RUN : S_HALT;
        end
        S_BREAK: begin
          if (!run_s) begin
            cur_state <= S_HALT;
          end else if (step_req) begin
            cur_state <= S_STEP;
            cpu_ce    <= 1'b1;
          end else begin
            bp_hit <= 1'b1;
          end
        end
        default: cur_state <= S_HALT;
      endcase
    end
  end

endmodule
